// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong types: direction codes, paddle FSM states, display size
package pong_pkg;

   localparam int D_WIDTH  = 640;
   localparam int D_HEIGHT = 480;

   // Direction codes are also decoded by the ball's collision logic.
   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_STILL = 2'd2;

   typedef enum logic [1:0] {
      ST_STILL = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } paddle_state_e;

   function automatic logic [1:0] dir_of(input paddle_state_e st);
      case (st)
         ST_LEFT:  dir_of = DIR_LEFT;
         ST_RIGHT: dir_of = DIR_RIGHT;
         default:  dir_of = DIR_STILL;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus stability counter for one raw button
module btn_debounce #(
   parameter int DB_CYCLES = 250000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_level
);

   localparam int CW = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle where the synced level agrees with the accepted one restarts qualification.
   always_comb begin
      sync1_d = i_btn;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_level = level_q;

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - player paddle: debounced buttons step the left-edge X once per animation strobe
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int WIDTH     = 100,
   parameter int HEIGHT    = 10,
   parameter int IX        = 270,
   parameter int IY        = 445,
   parameter int SPEED     = 2,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 540,
   parameter int DB_CYCLES = 250000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ani_stb,
   input  logic        i_animate,
   input  logic        i_btn_left,
   input  logic        i_btn_right,
   output logic [11:0] o_x,
   output logic [1:0]  o_dir,
   output logic [11:0] o_x1,
   output logic [11:0] o_x2,
   output logic [11:0] o_y1,
   output logic [11:0] o_y2
);

   localparam logic [11:0] IX_C    = 12'(IX);
   localparam logic [11:0] SPEED_C = 12'(SPEED);
   localparam logic [11:0] X_MIN_C = 12'(X_MIN);
   localparam logic [11:0] X_MAX_C = 12'(X_MAX);

   logic btn_l, btn_r;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_btn_left),
      .o_level (btn_l)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn   (i_btn_right),
      .o_level (btn_r)
   );

   paddle_state_e state_q, state_d, req_st;
   logic [11:0]   x_q, x_d, step_x;
   logic [1:0]    dir_q, dir_d;

   // Distance to the limit is compared before stepping so the unsigned X never wraps.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      dir_d   = dir_q;
      step_x  = x_q;
      req_st  = ST_STILL;
      if (i_animate && i_ani_stb) begin
         case ({btn_l, btn_r})
            2'b10: begin
               req_st = ST_LEFT;
               step_x = (x_q - X_MIN_C < SPEED_C) ? X_MIN_C : x_q - SPEED_C;
            end
            2'b01: begin
               req_st = ST_RIGHT;
               step_x = (X_MAX_C - x_q < SPEED_C) ? X_MAX_C : x_q + SPEED_C;
            end
            default: req_st = ST_STILL;
         endcase
         if (step_x == x_q) begin
            state_d = ST_STILL;
            dir_d   = DIR_STILL;
         end else begin
            state_d = req_st;
            x_d     = step_x;
            dir_d   = dir_of(req_st);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_STILL;
         x_q     <= IX_C;
         dir_q   <= DIR_STILL;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         dir_q   <= dir_d;
      end
   end

   assign o_x   = x_q;
   assign o_dir = dir_q;
   assign o_x1  = x_q;
   assign o_x2  = x_q + 12'(WIDTH);
   assign o_y1  = 12'(IY - HEIGHT / 2);
   assign o_y2  = 12'(IY + HEIGHT / 2);

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Player paddle controller for the Pong datapath. It debounces two raw push-buttons and steps the paddle's horizontal position once per animation strobe. It publishes the left-edge X and a motion-direction code, which the ball's collision logic consumes, plus the rectangle edges the renderer draws. One instance per player; paddle A sits at the bottom and paddle B at the top, selected by IY.

Parameters:
WIDTH, 100, paddle width in pixels; the ball treats the hit window as o_x..o_x+WIDTH
HEIGHT, 10, paddle height in pixels
IX, 270, reset value of the left-edge X
IY, 445, vertical centre of the paddle (fixed)
SPEED, 2, pixels moved per animation strobe
X_MIN, 0, minimum left-edge X
X_MAX, 540, maximum left-edge X (D_WIDTH-WIDTH)
DB_CYCLES, 250000, number of consecutive i_clk cycles a button must be stable before it is accepted

Ports:
i_clk  in  1  base clock
i_rst  in  1  reset, synchronous, active-high
i_ani_stb  in  1  animation strobe, one i_clk pulse per step
i_animate  in  1  movement enable; while low the paddle is frozen
i_btn_left  in  1  raw asynchronous button, active-high
i_btn_right  in  1  raw asynchronous button, active-high
o_x  out  12  paddle left-edge X, drives the ball's i_paddle_*_x
o_dir  out  2  motion code, drives the ball's i_paddle_*_dir: 0=right, 1=left, 2=still, 3 never driven
o_x1  out  12  left edge, equal to o_x
o_x2  out  12  right edge, o_x+WIDTH
o_y1  out  12  top edge, IY-HEIGHT/2
o_y2  out  12  bottom edge, IY+HEIGHT/2

Behaviour:
- Reset (i_rst=1 at a clock edge; takes priority over everything else):
  - o_x=IX, o_dir=2, state=STILL.
  - Synchronizer flops and debounced button levels cleared to 0; debounce counters cleared to 0.
- Input path per button:
  - 2-flop synchronizer, then debounce.
  - Debounce counter increments while the synced level differs from the accepted level, and clears to 0 when they match.
  - When the counter reaches DB_CYCLES-1 while still differing, the accepted level flips and the counter clears.
  - Latency from a stable raw edge to the accepted edge is DB_CYCLES+2 cycles.
  - Counter width is clog2(DB_CYCLES)+1.
- FSM states: STILL, LEFT, RIGHT. The state is evaluated only on cycles where i_animate && i_ani_stb; otherwise all state, o_x and o_dir hold.
- Next state from the debounced buttons (L, R):
  - L=1, R=0 -> LEFT.
  - L=0, R=1 -> RIGHT.
  - Both 0 or both 1 -> STILL.
- Position update on the same strobe:
  - LEFT: o_x = (o_x - X_MIN < SPEED) ? X_MIN : o_x - SPEED.
  - RIGHT: o_x = (X_MAX - o_x < SPEED) ? X_MAX : o_x + SPEED.
  - STILL: unchanged.
  - All arithmetic is unsigned 12-bit; the compare-before-subtract form guarantees no wrap below 0.
- Boundary:
  - If the requested move produces no change (already at X_MIN going left, or at X_MAX going right), the state goes to STILL and o_dir=2.
  - A partial clamp move (for example 1 px of a 2 px step) still reports the moving direction.
- o_dir is registered and updates on the same edge as o_x: LEFT->1, RIGHT->0, STILL->2.
- Outputs are valid one cycle after the strobe cycle.
- o_x1/o_x2/o_y1/o_y2 are combinational from o_x and parameters; o_y1/o_y2 are constant.
- A strobe with i_animate=0 is ignored entirely.
- i_rst asserted in the same cycle as a strobe: reset wins.

Decomposition:
- Shared package pong_pkg holds:
  - Direction codes DIR_RIGHT=2'd0, DIR_LEFT=2'd1, DIR_STILL=2'd2, also used by the ball.
  - The FSM state encoding.
  - Display constants D_WIDTH=640 and D_HEIGHT=480.
- One sub-module, btn_debounce (synchronizer plus counter, parameter DB_CYCLES), instantiated twice.

Test Plan:
All scenarios use DB_CYCLES=4, strobe every 8 clocks, and i_animate=1 unless noted.
- Reset, then hold i_btn_right=1 for 10 strobes -> after debounce latency, o_x steps 270,272,274...; o_dir=0 on every moving strobe; o_x2=o_x+100.
- Button glitch: i_btn_left high for 3 cycles, then low -> accepted level never rises; o_x stays 270, o_dir=2.
- Left clamp: start with o_x at 1 (IX=1), hold left -> next strobe o_x=0, o_dir=1; following strobe o_x=0, o_dir=2.
- Right clamp: IX=539, hold right -> o_x=540, o_dir=0; next strobe o_x=540, o_dir=2, no wrap past 540.
- Both buttons held -> o_dir=2 and o_x unchanged across 5 strobes; i_animate=0 with right held -> o_x frozen.
- Assert i_rst mid-movement at o_x=300, coincident with a strobe -> next cycle o_x=270, o_dir=2, and debounce must re-qualify a still-held button (DB_CYCLES+2 cycles) before motion resumes.
